// File: rtl/router_ctrl_fsm.sv
// rtl/router_ctrl_fsm.sv - 1x3 router packet-sequencing controller (Moore FSM)
// Optional WAIT_TILL_EMPTY timeout with drop pulse under `ROUTER_WAIT_TIMEOUT_EN.
module router_ctrl_fsm #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic [ADDR_W-1:0]    dest_addr,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 timeout_drop
);

    typedef enum logic [2:0] {
        ST_DA  = 3'd0,
        ST_LFD = 3'd1,
        ST_LD  = 3'd2,
        ST_FFS = 3'd3,
        ST_LAF = 3'd4,
        ST_LP  = 3'd5,
        ST_CPE = 3'd6,
        ST_WTE = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;

    logic hdr_ok;
    logic hdr_empty;
    logic sel_empty;
    logic sel_soft;

    // Per-port flags are picked with a compare loop so address codes beyond
    // NUM_PORTS never index past the flag vectors.
    always_comb begin
        hdr_ok    = pkt_valid && (32'(data_in) < NUM_PORTS);
        hdr_empty = 1'b0;
        sel_empty = 1'b0;
        sel_soft  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_in == ADDR_W'(i)) begin
                hdr_empty = fifo_empty[i];
            end
            if (dest_addr_q == ADDR_W'(i)) begin
                sel_empty = fifo_empty[i];
                sel_soft  = soft_reset[i];
            end
        end
    end

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_drop_q, timeout_drop_d;
    logic             wait_expired;

    // The counter sits at zero outside WTE, so it is clear on every entry.
    assign wait_cnt_d   = (state_q == ST_WTE) ? (wait_cnt_q + 1'b1) : '0;
    assign wait_expired = ((32'(wait_cnt_q) + 32'd1) == 32'(WAIT_TIMEOUT));
    assign timeout_drop = timeout_drop_q;
`else
    logic unused_wait_timeout;

    assign unused_wait_timeout = (WAIT_TIMEOUT > 0);
    assign timeout_drop        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dest_addr_d = dest_addr_q;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        timeout_drop_d = 1'b0;
`endif
        case (state_q)
            ST_DA: begin
                if (hdr_ok) begin
                    dest_addr_d = data_in;
                    state_d     = hdr_empty ? ST_LFD : ST_WTE;
                end
            end
            ST_LFD: state_d = ST_LD;
            ST_LD: begin
                if (fifo_full) begin
                    state_d = ST_FFS;
                end else if (!pkt_valid) begin
                    state_d = ST_LP;
                end
            end
            ST_FFS: begin
                if (!fifo_full) begin
                    state_d = ST_LAF;
                end
            end
            ST_LAF: begin
                if (parity_done) begin
                    state_d = ST_DA;
                end else if (low_pkt_valid) begin
                    state_d = ST_LP;
                end else begin
                    state_d = ST_LD;
                end
            end
            ST_LP:  state_d = ST_CPE;
            ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;
            ST_WTE: begin
                if (sel_empty) begin
                    state_d = ST_LFD;
                end
`ifdef ROUTER_WAIT_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d        = ST_DA;
                    timeout_drop_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_DA;
        endcase

        // A soft reset on the selected port abandons the packet from any busy state.
        if ((state_q != ST_DA) && sel_soft) begin
            state_d = ST_DA;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            timeout_drop_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_DA;
            dest_addr_q <= '0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_drop_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dest_addr_q <= dest_addr_d;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            timeout_drop_q <= timeout_drop_d;
`endif
        end
    end

    assign dest_addr     = dest_addr_q;
    assign detect_add    = (state_q == ST_DA);
    assign lfd_state     = (state_q == ST_LFD);
    assign ld_state      = (state_q == ST_LD);
    assign laf_state     = (state_q == ST_LAF);
    assign full_state    = (state_q == ST_FFS);
    assign rst_int_reg   = (state_q == ST_CPE);
    assign write_enb_reg = (state_q == ST_LD) || (state_q == ST_LAF) || (state_q == ST_LP);
    assign busy          = !((state_q == ST_DA) || (state_q == ST_LD));

endmodule
